// File: rtl/bcd_digit_accumulator_if.sv
// Handshake bundle between the BCD digit source, the accumulator and the
// consumer of the assembled binary word.
interface bcd_digit_accumulator_if #(
  parameter int OUT_W = 14
);
  logic             clear;
  logic [3:0]       digit;
  logic             digit_valid;
  logic             digit_ready;
  logic [OUT_W-1:0] bin_out;
  logic             bin_valid;
  logic             bin_ready;
  logic             bin_err;
  logic [3:0]       digit_cnt;

  // Source/consumer side: drives digits, flush and output backpressure.
  modport master (
    output clear, digit, digit_valid, bin_ready,
    input  digit_ready, bin_out, bin_valid, bin_err, digit_cnt
  );

  // Accumulator side.
  modport slave (
    input  clear, digit, digit_valid, bin_ready,
    output digit_ready, bin_out, bin_valid, bin_err, digit_cnt
  );
endinterface

// File: rtl/bcd_digit_accumulator.sv
// Assembles NUM_DIGITS BCD digits (MSD first) into one unsigned binary word
// and flags words that contained a non-BCD code (10-15).
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting digits, acc = acc*10 + digit on every accept
// HOLD  | complete word on bin_out, waiting for bin_ready; no digit accept
module bcd_digit_accumulator #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_digit_accumulator_if.slave  bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(NUM_DIGITS - 1);

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             err_acc_q, err_acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] bin_out_q, bin_out_d;
  logic             bin_err_q, bin_err_d;

  logic             digit_ready;
  logic             accept;
  logic             digit_bad;
  logic [3:0]       digit_val;
  logic [OUT_W-1:0] acc_x10;
  logic [OUT_W-1:0] acc_next;
  logic             err_next;

  // Ready depends only on registered state plus the flush/reset inputs, never
  // on bin_ready, so no combinational path runs consumer -> producer.
  assign digit_ready = (state_q == ACCUM) && !rst && !bus.clear;
  assign accept      = bus.digit_valid && digit_ready;

  // Digit decode and the acc*10 + d datapath. The x10 is built from two
  // shifts; keeping only OUT_W bits is the same as truncating the wider sum,
  // and the width rule on OUT_W guarantees nothing is lost either way.
  always_comb begin
    digit_bad = 1'b0;
    digit_val = 4'd0;
    if (accept) begin
      digit_bad = (bus.digit > 4'd9);
      digit_val = digit_bad ? 4'd0 : bus.digit;
    end
    acc_x10  = (acc_q << 3) + (acc_q << 1);
    acc_next = acc_x10 + OUT_W'(digit_val);
    err_next = err_acc_q | digit_bad;
  end

  // Next-state and datapath updates; clear overrides every handshake.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    err_acc_d = err_acc_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    bin_err_d = bin_err_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d     = acc_next;
          err_acc_d = err_next;
          if (cnt_q == LAST_CNT) begin
            state_d   = HOLD;
            cnt_d     = 4'd0;
            bin_out_d = acc_next;
            bin_err_d = err_next;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (bus.bin_ready) begin
          state_d   = ACCUM;
          acc_d     = '0;
          err_acc_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (bus.clear) begin
      state_d   = ACCUM;
      acc_d     = '0;
      err_acc_d = 1'b0;
      cnt_d     = 4'd0;
      bin_err_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      err_acc_q <= 1'b0;
      cnt_q     <= 4'd0;
      bin_out_q <= '0;
      bin_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      err_acc_q <= err_acc_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      bin_err_q <= bin_err_d;
    end
  end

  assign bus.digit_ready = digit_ready;
  assign bus.bin_valid   = (state_q == HOLD);
  assign bus.bin_out     = bin_out_q;
  assign bus.bin_err     = bin_err_q;
  assign bus.digit_cnt   = cnt_q;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Scoreboard bench for bcd_digit_accumulator: a reference model turns the
// accepted digit stream into expected words, a monitor compares them.
module tb_bcd_digit_accumulator;

  localparam int NUM = 4;
  localparam int OW  = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_digit_accumulator_if #(.OUT_W(OW)) ifc ();

  bcd_digit_accumulator #(.NUM_DIGITS(NUM), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    int unsigned value;
    bit          err;
  } word_t;

  word_t       sb[$];
  int unsigned digits_q[$];
  bit          m_hold = 1'b0;
  bit          m_init = 1'b0;
  int          checks = 0;
  int          errors = 0;

  bit rand_bp  = 1'b0;
  bit rand_clr = 1'b0;
  bit br_fixed = 1'b1;
  bit clr_fixed = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word from the accepted digits: positional decimal value, any
  // code above 9 counts as zero and marks the word as erroneous.
  function automatic word_t make_word();
    word_t w;
    w.value = 0;
    w.err   = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      int unsigned p = 1;
      for (int k = 0; k < NUM - 1 - i; k++) p = p * 10;
      if (digits_q[i] > 9) w.err = 1'b1;
      else w.value = w.value + digits_q[i] * p;
    end
    return w;
  endfunction

  // Reference model, evaluated on the same edge the DUT samples inputs.
  always @(posedge clk) begin
    m_init <= 1'b1;
    if (rst || ifc.clear) begin
      digits_q.delete();
      if (m_hold && sb.size() > 0) void'(sb.pop_front());
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (ifc.bin_ready) m_hold = 1'b0;
    end else if (ifc.digit_valid) begin
      digits_q.push_back(int'(ifc.digit));
      if (digits_q.size() == NUM) begin
        sb.push_back(make_word());
        digits_q.delete();
        m_hold = 1'b1;
      end
    end
  end

  // Monitor: handshake flags every cycle, word contents whenever presented.
  always @(negedge clk) begin
    if (m_init) begin
      chk("digit_ready", longint'(ifc.digit_ready), longint'(!m_hold && !rst && !ifc.clear));
      chk("bin_valid", longint'(ifc.bin_valid), longint'(m_hold));
      chk("digit_cnt", longint'(ifc.digit_cnt), longint'(digits_q.size()));
      if (ifc.bin_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got bin_out=%0d with no expected word at %0t",
                   ifc.bin_out, $time);
        end else begin
          chk("bin_out", longint'(ifc.bin_out), longint'(sb[0].value));
          chk("bin_err", longint'(ifc.bin_err), longint'(sb[0].err));
          if (ifc.bin_ready && !ifc.clear && !rst) void'(sb.pop_front());
        end
      end
    end
  end

  // Sole driver of bin_ready and clear: fixed values or random traffic.
  always @(posedge clk) begin
    #2;
    ifc.bin_ready = rand_bp  ? 1'($urandom_range(0, 1)) : br_fixed;
    ifc.clear     = rand_clr ? ($urandom_range(0, 39) == 0) : clr_fixed;
  end

  task automatic drive_digit(input logic [3:0] d);
    ifc.digit       = d;
    ifc.digit_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ifc.digit_ready) begin
        @(posedge clk);
        #1;
        ifc.digit_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL digit_timeout: got no digit_ready expected accept of %0d", d);
    ifc.digit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ifc.digit_valid = 1'b0;
    repeat (n) begin
      ifc.digit = 4'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input int d0, input int d1, input int d2, input int d3);
    drive_digit(4'(d0));
    drive_digit(4'(d1));
    drive_digit(4'(d2));
    drive_digit(4'(d3));
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    chk("rst_bin_out", longint'(ifc.bin_out), 0);
    chk("rst_bin_err", longint'(ifc.bin_err), 0);
    chk("rst_bin_valid", longint'(ifc.bin_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((m_hold || sb.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
    end
  endtask

  initial begin
    ifc.digit       = 4'd0;
    ifc.digit_valid = 1'b0;
    ifc.bin_ready   = 1'b1;
    ifc.clear       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs();

    // Basic words, including the error digit and the per-word error reset.
    br_fixed = 1'b1;
    send_word(1, 2, 3, 4);
    send_word(9, 9, 9, 9);
    send_word(0, 0, 0, 0);
    send_word(1, 13, 3, 4);
    send_word(5, 6, 7, 8);
    idle(2);

    // Backpressure: next digit held valid while the word waits.
    br_fixed = 1'b0;
    send_word(4, 3, 2, 1);
    fork
      drive_digit(4'd9);
      begin
        repeat (6) @(posedge clk);
        #1;
        br_fixed = 1'b1;
      end
    join
    drive_digit(4'd8);
    drive_digit(4'd7);
    drive_digit(4'd6);
    idle(2);

    // Gapped input.
    drive_digit(4'd7);
    idle(2);
    drive_digit(4'd0);
    idle(1);
    drive_digit(4'd0);
    drive_digit(4'd7);
    idle(2);

    // Aborted word via reset, then via clear.
    drive_digit(4'd8);
    drive_digit(4'd8);
    rst = 1'b1;
    ifc.digit_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.digit_valid = 1'b0;
    check_reset_outputs();
    send_word(5, 6, 7, 8);
    idle(1);
    drive_digit(4'd8);
    drive_digit(4'd8);
    clr_fixed = 1'b1;
    ifc.digit_valid = 1'b1;
    @(posedge clk);
    #1;
    clr_fixed = 1'b0;
    ifc.digit_valid = 1'b0;
    idle(1);
    send_word(5, 6, 7, 8);
    drain();

    // Randomized traffic with backpressure, gaps, bad codes and flushes.
    rand_bp  = 1'b1;
    rand_clr = 1'b1;
    for (int w = 0; w < 60; w++) begin
      for (int i = 0; i < NUM; i++) begin
        logic [3:0] d;
        if ($urandom_range(0, 5) == 0) d = 4'($urandom_range(10, 15));
        else d = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        drive_digit(d);
      end
    end
    rand_bp  = 1'b0;
    rand_clr = 1'b0;
    br_fixed = 1'b1;
    clr_fixed = 1'b0;
    @(posedge clk);
    #1;
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
